// File: rtl/spi_pkg.sv
// Shared SPI definitions for the master and slave datapaths.
// Word size, synchroniser depth, FSM encodings and bus mode.
package spi_pkg;

  localparam int DEF_DATA_WIDTH  = 12;
  localparam int DEF_SYNC_STAGES = 2;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;
  localparam logic [1:0] SPI_MODE = {SPI_CPOL, SPI_CPHA};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_slave_mosi_rx_if.sv
// Valid/ready word stream from the SPI slave receive path.
// master drives words and status pulses; slave consumes them.
interface spi_slave_mosi_rx_if
  import spi_pkg::*;
#(
  parameter int DW = DEF_DATA_WIDTH
) ();

  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          overrun;
  logic          frame_err;

  modport master (
    output rx_data,
    output rx_valid,
    output overrun,
    output frame_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  overrun,
    input  frame_err,
    output rx_ready
  );

endinterface

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for one async input plus edge detect.
// Flops reset to the line's idle level to avoid false edges.
module spi_edge_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Shift the async level through the chain; keep one history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~hist_q;
  assign fall_o = ~q_o & hist_q;

endmodule

// File: rtl/spi_slave_mosi_rx.sv
// SPI mode-0 slave receive path: assembles MSB-first words on mosi
// and hands them downstream on a valid/ready stream in the clk domain.
module spi_slave_mosi_rx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sck,
  input  logic                ssel,
  input  logic                mosi,
  spi_slave_mosi_rx_if.master rx_if
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic sck_s;
  logic sck_rise;
  logic unused_sck_fall;
  logic ssel_s;
  logic unused_ssel_rise;
  logic unused_ssel_fall;
  logic mosi_s;
  logic unused_mosi_rise;
  logic unused_mosi_fall;

  spi_edge_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sck_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sck),
    .q_o    (sck_s),
    .rise_o (sck_rise),
    .fall_o (unused_sck_fall)
  );

  spi_edge_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_ssel_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (ssel),
    .q_o    (ssel_s),
    .rise_o (unused_ssel_rise),
    .fall_o (unused_ssel_fall)
  );

  spi_edge_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_mosi_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (mosi),
    .q_o    (mosi_s),
    .rise_o (unused_mosi_rise),
    .fall_o (unused_mosi_fall)
  );

  spi_state_e            state_q;
  logic [CW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic                  overrun_q;
  logic                  frame_err_q;
  logic [DATA_WIDTH-1:0] word_d;

  assign word_d = {shift_q[DATA_WIDTH-2:0], mosi_s};

  // Frame FSM, shifter and output stage; ssel release beats a
  // coincident sck rise so a dying frame never gains a bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      if (rx_valid_q && rx_if.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      unique case (state_q)
        ST_IDLE: begin
          bit_cnt_q <= '0;
          if (!ssel_s) begin
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (ssel_s) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            if (bit_cnt_q != '0) begin
              frame_err_q <= 1'b1;
            end
          end else if (sck_rise) begin
            shift_q <= word_d;
            if (bit_cnt_q == LAST) begin
              bit_cnt_q <= '0;
              if (!rx_valid_q || rx_if.rx_ready) begin
                rx_data_q  <= word_d;
                rx_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          bit_cnt_q <= '0;
        end
      endcase
    end
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_valid  = rx_valid_q;
  assign rx_if.overrun   = overrun_q;
  assign rx_if.frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_mosi_rx.sv
// Directed bench for the SPI slave receive path.
// Expected words and pulse counts are written out by hand.
module tb_spi_slave_mosi_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck = 1'b0;
  logic ssel = 1'b1;
  logic mosi = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int beat_tot = 0;
  int valid_tot = 0;
  int ovr_tot = 0;
  int ferr_tot = 0;
  int first_valid_cyc = 0;
  int rise_cyc = 0;
  logic prev_valid = 1'b0;
  logic [11:0] beats[$];

  spi_slave_mosi_rx_if #(.DW(12)) rx_if ();

  spi_slave_mosi_rx #(
    .DATA_WIDTH  (12),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sck   (sck),
    .ssel  (ssel),
    .mosi  (mosi),
    .rx_if (rx_if.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_if.rx_valid && rx_if.rx_ready) begin
      beats.push_back(rx_if.rx_data);
      beat_tot = beat_tot + 1;
    end
    if (rx_if.rx_valid) valid_tot = valid_tot + 1;
    if (rx_if.rx_valid && !prev_valid) first_valid_cyc = cyc;
    prev_valid = rx_if.rx_valid;
    if (rx_if.overrun) ovr_tot = ovr_tot + 1;
    if (rx_if.frame_err) ferr_tot = ferr_tot + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [11:0] beat_at(input int idx);
    if (idx < beats.size()) return beats[idx];
    return 12'hxxx;
  endfunction

  // Mode 0: data changes while sck low, sampled on the rise.
  // pulse=1 raises rx_ready for one cycle in the last bit's
  // completion cycle.
  task automatic shift_bits(input logic [11:0] w, input int n,
                            input bit pulse);
    for (int i = 0; i < n; i++) begin
      sck = 1'b0;
      mosi = w[11-i];
      clks(8);
      sck = 1'b1;
      rise_cyc = cyc;
      if (pulse && i == n - 1) begin
        clks(2);
        rx_if.rx_ready = 1'b1;
        clks(1);
        rx_if.rx_ready = 1'b0;
        clks(5);
      end else begin
        clks(8);
      end
    end
    sck = 1'b0;
    clks(8);
  endtask

  task automatic frame(input logic [11:0] w);
    ssel = 1'b0;
    clks(6);
    shift_bits(w, 12, 1'b0);
    ssel = 1'b1;
    clks(8);
  endtask

  int b0, v0, o0, f0, lat;

  initial begin
    rx_if.rx_ready = 1'b1;
    clks(4);
    chk("rst_valid", {31'd0, rx_if.rx_valid}, 32'd0);
    chk("rst_data", {20'd0, rx_if.rx_data}, 32'd0);
    chk("rst_ovr", {31'd0, rx_if.overrun}, 32'd0);
    chk("rst_ferr", {31'd0, rx_if.frame_err}, 32'd0);
    rst = 1'b0;
    clks(4);

    // single word
    b0 = beat_tot; v0 = valid_tot; f0 = ferr_tot;
    frame(12'hA5C);
    lat = first_valid_cyc - rise_cyc;
    chk("t1_beats", beat_tot - b0, 1);
    chk("t1_data", {20'd0, beat_at(b0)}, 32'h0A5C);
    chk("t1_vcyc", valid_tot - v0, 1);
    chk("t1_lat", {31'd0, (lat >= 3 && lat <= 5)}, 32'd1);
    chk("t1_ferr", ferr_tot - f0, 0);

    // back-to-back in one frame
    b0 = beat_tot; o0 = ovr_tot; f0 = ferr_tot;
    ssel = 1'b0;
    clks(6);
    shift_bits(12'h123, 12, 1'b0);
    shift_bits(12'hFED, 12, 1'b0);
    ssel = 1'b1;
    clks(8);
    chk("t2_beats", beat_tot - b0, 2);
    chk("t2_d0", {20'd0, beat_at(b0)}, 32'h0123);
    chk("t2_d1", {20'd0, beat_at(b0 + 1)}, 32'h0FED);
    chk("t2_ovr", ovr_tot - o0, 0);
    chk("t2_ferr", ferr_tot - f0, 0);

    // backpressure and overrun
    rx_if.rx_ready = 1'b0;
    b0 = beat_tot; o0 = ovr_tot;
    ssel = 1'b0;
    clks(6);
    shift_bits(12'h0F0, 12, 1'b0);
    shift_bits(12'h555, 12, 1'b0);
    ssel = 1'b1;
    clks(8);
    chk("t3_valid", {31'd0, rx_if.rx_valid}, 32'd1);
    chk("t3_hold", {20'd0, rx_if.rx_data}, 32'h00F0);
    chk("t3_ovr", ovr_tot - o0, 1);
    rx_if.rx_ready = 1'b1;
    clks(2);
    chk("t3_beats", beat_tot - b0, 1);
    chk("t3_data", {20'd0, beat_at(b0)}, 32'h00F0);
    chk("t3_fall", {31'd0, rx_if.rx_valid}, 32'd0);

    // accept coincident with completion
    rx_if.rx_ready = 1'b0;
    b0 = beat_tot; o0 = ovr_tot;
    ssel = 1'b0;
    clks(6);
    shift_bits(12'hAAA, 12, 1'b0);
    shift_bits(12'h333, 12, 1'b1);
    ssel = 1'b1;
    clks(8);
    chk("t4_valid", {31'd0, rx_if.rx_valid}, 32'd1);
    chk("t4_data", {20'd0, rx_if.rx_data}, 32'h0333);
    chk("t4_ovr", ovr_tot - o0, 0);
    chk("t4_acc", {20'd0, beat_at(b0)}, 32'h0AAA);
    rx_if.rx_ready = 1'b1;
    clks(2);
    chk("t4_beat2", {20'd0, beat_at(b0 + 1)}, 32'h0333);

    // aborted frame
    b0 = beat_tot; f0 = ferr_tot;
    ssel = 1'b0;
    clks(6);
    shift_bits(12'hFFF, 7, 1'b0);
    ssel = 1'b1;
    clks(8);
    chk("t5_ferr", ferr_tot - f0, 1);
    chk("t5_nobeat", beat_tot - b0, 0);
    frame(12'h801);
    chk("t5_beats", beat_tot - b0, 1);
    chk("t5_data", {20'd0, beat_at(b0)}, 32'h0801);

    // reset mid-word
    b0 = beat_tot; f0 = ferr_tot;
    ssel = 1'b0;
    clks(6);
    shift_bits(12'h3C3, 5, 1'b0);
    rst = 1'b1;
    ssel = 1'b1;
    clks(3);
    chk("t6_valid", {31'd0, rx_if.rx_valid}, 32'd0);
    chk("t6_data", {20'd0, rx_if.rx_data}, 32'd0);
    chk("t6_ovr", {31'd0, rx_if.overrun}, 32'd0);
    rst = 1'b0;
    clks(6);
    chk("t6_ferr", ferr_tot - f0, 0);
    frame(12'h7E7);
    chk("t6_beats", beat_tot - b0, 1);
    chk("t6_next", {20'd0, beat_at(b0)}, 32'h07E7);
    b0 = beat_tot;
    shift_bits(12'hFFF, 12, 1'b0);
    chk("t6_desel", beat_tot - b0, 0);
    chk("t6_dvalid", {31'd0, rx_if.rx_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_mosi_rx.md
Name: spi_slave_mosi_rx

Overview:
- SPI slave receive path: recovers DATA_WIDTH-bit words that the master shifts out on mosi.
- Counterpart to the existing master-side receive (miso) path; completes the full-duplex link between spi_master and spi_slave.
- All SPI inputs are asynchronous to clk. They are oversampled and synchronised.
- Completed words are presented on a valid/ready handshake to downstream logic in the clk domain.

Parameters:
- DATA_WIDTH, 12, bits per SPI word; MSB first.
- SYNC_STAGES, 2, synchroniser flops per async input; minimum 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- sck  input  1  SPI clock from master; mode 0 (CPOL=0, CPHA=0); asynchronous.
- ssel  input  1  slave select, active-low; asynchronous.
- mosi  input  1  serial data from master; asynchronous.
- rx_data  output  DATA_WIDTH  last completed word; stable while rx_valid=1.
- rx_valid  output  1  word available; held until accepted.
- rx_ready  input  1  consumer accepts word when rx_valid&&rx_ready.
- overrun  output  1  one-cycle pulse: word completed while previous still pending; new word dropped.
- frame_err  output  1  one-cycle pulse: ssel deasserted with partial word (1..DATA_WIDTH-1 bits).

Behaviour:
- Reset (rst=1 at a clk edge): rx_data=0, rx_valid=0, overrun=0, frame_err=0, bit_cnt=0, shift register=0, state=IDLE. Synchroniser flops are set to the idle levels sck=0, ssel=1, mosi=0.
- Synchronisation: sck, ssel and mosi each pass through SYNC_STAGES flops plus one history flop for edge detection.
  - sck_rise = synced sck is 1 and history is 0.
  - ssel_fall and ssel_rise are derived the same way.
- Timing requirement: sck high time ≥ 3 clk and sck low time ≥ 3 clk. Faster sck is unsupported; behaviour is then undefined but must not lock up (rst recovers).
- mosi is sampled from its synchronised copy in the same cycle that sck_rise is detected. Both signals see identical sync delay.
- FSM:
  - IDLE: waits for synced ssel=0, then → SHIFT with bit_cnt=0. sck edges while ssel=1 are ignored.
  - SHIFT, on each sck_rise: shift_reg <= {shift_reg[DATA_WIDTH-2:0], mosi_s}; bit_cnt++.
  - SHIFT, on the DATA_WIDTH-th rise: word complete. bit_cnt wraps to 0 and the FSM stays in SHIFT, so back-to-back words are allowed within one frame.
  - SHIFT, when synced ssel=1: → IDLE. If bit_cnt≠0, pulse frame_err for 1 cycle and discard the partial word. bit_cnt clears.
- Word completion in cycle N:
  - If rx_valid=0, or rx_valid=1 with rx_ready=1 in cycle N: rx_data <= assembled word, rx_valid <= 1 (visible in N+1).
  - If rx_valid=1 and rx_ready=0: keep old rx_data and rx_valid; overrun=1 for cycle N+1.
- Handshake: rx_valid clears the cycle after rx_valid&&rx_ready unless a new word is loaded in the same cycle. Simultaneous accept and completion leaves rx_valid=1 holding the new data, with no gap and no overrun.
- Latency: rx_valid rises SYNC_STAGES+2 clk edges after the final sck rising edge (±1 clk from async sampling).
- Simultaneous sck_rise and ssel_rise in one cycle: the ssel rise wins. The bit is not shifted and the frame is aborted per the rules above.
- rst mid-word: partial data is lost, no frame_err pulse, and the FSM returns to IDLE. The first word of the next frame is received normally.

Decomposition:
- spi_pkg (shared with spi_master and spi_slave): DATA_WIDTH default; SYNC_STAGES default; FSM state encodings ST_IDLE and ST_SHIFT; SPI mode constant (CPOL=0, CPHA=0).
- Sub-module spi_edge_sync: a parameterised synchroniser plus rise/fall detector with a reset level parameter. It is instantiated three times (sck, ssel, mosi; the mosi instance does not use edge outputs) and is reusable by spi_master for miso.

Test Plan:
- Single word: ssel low, shift 12'hA5C MSB-first at sck period 16 clk, then ssel high, rx_ready=1 → rx_data=12'hA5C, rx_valid high for exactly 1 cycle, SYNC_STAGES+2 (±1) clk after the 12th sck rise; frame_err=0.
- Back-to-back: one frame carrying 12'h123 then 12'hFED, rx_ready=1 → two valid beats with data 0x123 then 0xFED; overrun=0; frame_err=0.
- Backpressure/overrun: rx_ready=0; send 12'h0F0 then 12'h555 → rx_data stays 0x0F0 with rx_valid=1; one overrun pulse; after raising rx_ready, one beat of 0x0F0 and rx_valid falls.
- Accept coincident with completion: hold 12'hAAA pending and pulse rx_ready exactly in the completion cycle of 12'h333 → rx_valid stays 1, rx_data=0x333, overrun=0.
- Aborted frame: ssel high after 7 bits of 12'hFFF → one frame_err pulse, no rx_valid; the next full frame 12'h801 is received correctly.
- Reset mid-word: assert rst after 5 bits → all outputs 0, no frame_err pulse; the next frame 12'h7E7 is received correctly; sck toggling while ssel=1 produces no rx_valid.
